// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler
//   Round-robin arbiter plus frame sequencer for four transmit channels that
//   share one serial line. Frame on the line: start(0), 2-bit channel ID
//   (MSB first), DW data bits (LSB first), stop(1). The FSM advances only on
//   step_en cycles; ack and frame_done are single-clk pulses.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   step_en    one-clk advance strobe
//   req        per-channel transmit request (level)
//   data_in    channel c payload on [c*DW +: DW]
//   ack        one-hot pulse: granted channel's data captured
//   ser_out    serial line, idles high
//   busy       frame in progress (any state except IDLE)
//   cur_ch     channel being sent; holds last value in IDLE
//   frame_done pulse on the step that leaves STOP
module serial_tx_scheduler #(
    parameter int DW  = 8,
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_en,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] data_in,
    output logic [NCH-1:0]    ack,
    output logic              ser_out,
    output logic              busy,
    output logic [1:0]        cur_ch,
    output logic              frame_done
);

    // Counter must hold 1 (ID phase) and DW-1 (DATA phase).
    localparam int CW = (DW < 2) ? 1 : $clog2(DW + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ID    = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   shift, shift_n;
    logic [1:0]      rr_ptr, rr_ptr_n;
    logic [1:0]      cur_ch_n;
    logic [NCH-1:0]  ack_n;
    logic            frame_done_n;

    logic            gnt_vld;
    logic [1:0]      gnt_ch;
    logic [DW-1:0]   ch_data [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_slice
        assign ch_data[g] = data_in[g*DW +: DW];
    end

    // Round-robin search: scan from farthest offset down to nearest so the
    // channel right after rr_ptr is the last (and therefore winning) match.
    // Offset 4 wraps to rr_ptr itself, giving it lowest priority.
    always_comb begin
        logic [1:0] cand;
        gnt_vld = 1'b0;
        gnt_ch  = rr_ptr;
        cand    = rr_ptr;
        for (int i = NCH; i >= 1; i--) begin
            cand = rr_ptr + 2'(i);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shift_n      = shift;
        rr_ptr_n     = rr_ptr;
        cur_ch_n     = cur_ch;
        ack_n        = '0;
        frame_done_n = 1'b0;
        if (step_en) begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        shift_n       = ch_data[gnt_ch];
                        cur_ch_n      = gnt_ch;
                        rr_ptr_n      = gnt_ch;
                        ack_n[gnt_ch] = 1'b1;
                        state_n       = START;
                    end
                end
                START: begin
                    state_n = ID;
                    cnt_n   = CW'(1);
                end
                ID: begin
                    if (cnt == '0) state_n = DATA;
                    else           cnt_n   = cnt - CW'(1);
                end
                DATA: begin
                    shift_n = shift >> 1;
                    if (cnt == CW'(DW - 1)) begin
                        state_n = STOP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                STOP: begin
                    state_n      = IDLE;
                    frame_done_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shift      <= '0;
            rr_ptr     <= 2'd3;
            cur_ch     <= 2'd0;
            ack        <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            rr_ptr     <= rr_ptr_n;
            cur_ch     <= cur_ch_n;
            ack        <= ack_n;
            frame_done <= frame_done_n;
        end
    end

    // Line value is a pure decode of registered state.
    always_comb begin
        ser_out = 1'b1;
        case (state)
            IDLE:    ser_out = 1'b1;
            START:   ser_out = 1'b0;
            ID:      ser_out = cur_ch[cnt[0]];
            DATA:    ser_out = shift[0];
            STOP:    ser_out = 1'b1;
            default: ser_out = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
